// File: rtl/memory_access_pkg.sv
// Shared definitions for the M-stage memory access unit.
// Covers state encoding, funct3 access codes and the lane/alignment helpers.
package memory_access_pkg;

   localparam int SIZE_W = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_D  = 3'd3;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   localparam logic [2:0] F3_WU = 3'd6;

   // Access size as log2 of the byte count.
   localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
   localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
   localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
   localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

   function automatic logic [SIZE_W-1:0] f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         F3_W, F3_WU: return SZ_W;
         default:     return SZ_D;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] off, input logic [SIZE_W-1:0] sz);
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   function automatic logic [7:0] byte_strobe(input logic [2:0] off, input logic [SIZE_W-1:0] sz);
      case (sz)
         SZ_B:    return 8'h01 << off;
         SZ_H:    return 8'h03 << off;
         SZ_W:    return 8'h0F << off;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/memory_access_load_extract.sv
// Picks the addressed bytes out of a returned doubleword and sign/zero-extends them.
module load_extract
   import memory_access_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      off_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      case (funct3_i)
         F3_B:    result_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_H:    result_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_W:    result_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_BU:   result_o = {{(XLEN-8){1'b0}},         shifted[7:0]};
         F3_HU:   result_o = {{(XLEN-16){1'b0}},        shifted[15:0]};
         F3_WU:   result_o = {{(XLEN-32){1'b0}},        shifted[31:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// M-stage memory access unit: issues one dcache request per load/store and stalls
// the pipeline until the response has been captured.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            regM_i_mem_ren,
   input  logic            regM_i_mem_wen,
   input  logic [2:0]      regM_i_funct3,
   input  logic [XLEN-1:0] regM_i_alu_result,
   input  logic [XLEN-1:0] regM_i_store_data,
   output logic            mem_o_req_valid,
   input  logic            mem_i_req_ready,
   output logic [XLEN-1:0] mem_o_addr,
   output logic            mem_o_wen,
   output logic [XLEN-1:0] mem_o_wdata,
   output logic [7:0]      mem_o_wstrb,
   input  logic            mem_i_resp_valid,
   input  logic [XLEN-1:0] mem_i_resp_rdata,
   output logic [XLEN-1:0] memory_o_memdata,
   output logic            memory_o_stall_req,
   output logic            memory_o_misalign,
   output logic [1:0]      dbg_state_o
);

   logic [1:0]        state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [7:0]        wstrb_q, wstrb_d;
   logic              ren_q, ren_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [2:0]        off_q, off_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              access;
   logic              misaligned;
   logic              start;
   logic [2:0]        off_in;
   logic [SIZE_W-1:0] size_in;
   logic [XLEN-1:0]   addr_in;
   logic [XLEN-1:0]   wdata_in;
   logic [7:0]        wstrb_in;
   logic [XLEN-1:0]   load_val;

   assign off_in     = regM_i_alu_result[2:0];
   assign size_in    = f3_size(regM_i_funct3);
   assign access     = regM_i_mem_ren | regM_i_mem_wen;
   assign misaligned = is_misaligned(off_in, size_in);
   assign start      = !rst && (state_q == ST_IDLE) && access && !misaligned;

   assign addr_in  = {regM_i_alu_result[XLEN-1:3], 3'b000};
   assign wdata_in = regM_i_mem_wen ? (regM_i_store_data << {off_in, 3'b000}) : '0;
   assign wstrb_in = regM_i_mem_wen ? byte_strobe(off_in, size_in) : 8'h00;

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .rdata_i  (mem_i_resp_rdata),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .result_o (load_val)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      ren_d    = ren_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d   = addr_in;
               wen_d    = regM_i_mem_wen;
               wdata_d  = wdata_in;
               wstrb_d  = wstrb_in;
               ren_d    = regM_i_mem_ren;
               funct3_d = regM_i_funct3;
               off_d    = off_in;
               state_d  = mem_i_req_ready ? ST_WAIT : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_i_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_i_resp_valid) begin
               result_d = ren_q ? load_val : '0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= 8'h00;
         ren_q    <= 1'b0;
         funct3_q <= 3'd0;
         off_q    <= 3'd0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         ren_q    <= ren_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         result_q <= result_d;
      end
   end

   // Request handshake: a request transfers on a rising edge where valid and ready are both
   // high; once valid rises it stays high with stable fields until that edge.
   assign mem_o_req_valid    = start | (state_q == ST_REQ);
   assign mem_o_addr         = start ? addr_in        : addr_q;
   assign mem_o_wen          = start ? regM_i_mem_wen : wen_q;
   assign mem_o_wdata        = start ? wdata_in       : wdata_q;
   assign mem_o_wstrb        = start ? wstrb_in       : wstrb_q;
   assign memory_o_stall_req = start | (state_q == ST_REQ) | (state_q == ST_WAIT);
   assign memory_o_misalign  = !rst && (state_q == ST_IDLE) && access && misaligned;
   assign memory_o_memdata   = (state_q == ST_DONE) ? result_q : '0;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a queue-based scoreboard and passive monitor.
module tb_memory_access;
   import memory_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        regM_i_mem_ren = 1'b0;
   logic        regM_i_mem_wen = 1'b0;
   logic [2:0]  regM_i_funct3 = 3'd0;
   logic [63:0] regM_i_alu_result = 64'd0;
   logic [63:0] regM_i_store_data = 64'd0;
   logic        mem_o_req_valid;
   logic        mem_i_req_ready = 1'b0;
   logic [63:0] mem_o_addr;
   logic        mem_o_wen;
   logic [63:0] mem_o_wdata;
   logic [7:0]  mem_o_wstrb;
   logic        mem_i_resp_valid = 1'b0;
   logic [63:0] mem_i_resp_rdata = 64'd0;
   logic [63:0] memory_o_memdata;
   logic        memory_o_stall_req;
   logic        memory_o_misalign;
   logic [1:0]  dbg_state_o;

   memory_access #(.XLEN(64)) dut (
      .clk                (clk),
      .rst                (rst),
      .regM_i_mem_ren     (regM_i_mem_ren),
      .regM_i_mem_wen     (regM_i_mem_wen),
      .regM_i_funct3      (regM_i_funct3),
      .regM_i_alu_result  (regM_i_alu_result),
      .regM_i_store_data  (regM_i_store_data),
      .mem_o_req_valid    (mem_o_req_valid),
      .mem_i_req_ready    (mem_i_req_ready),
      .mem_o_addr         (mem_o_addr),
      .mem_o_wen          (mem_o_wen),
      .mem_o_wdata        (mem_o_wdata),
      .mem_o_wstrb        (mem_o_wstrb),
      .mem_i_resp_valid   (mem_i_resp_valid),
      .mem_i_resp_rdata   (mem_i_resp_rdata),
      .memory_o_memdata   (memory_o_memdata),
      .memory_o_stall_req (memory_o_stall_req),
      .memory_o_misalign  (memory_o_misalign),
      .dbg_state_o        (dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [136:0] exp_req_q[$];   // {addr, wen, wdata, wstrb}
   logic [63:0]  exp_mem_q[$];
   logic [7:0]   exp_stall_q[$];
   logic [1:0]   exp_mis_q[$];   // {req_valid, stall_req} during a misalign cycle
   int           n_checks = 0;
   int           n_pass   = 0;
   bit           mon_en   = 1'b0;
   int           stall_run = 0;
   logic [136:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      $display("FAIL %s: got event, expected none", name);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_o_req_valid) begin
            if (exp_req_q.size() == 0) fail_evt("req_unexpected");
            else begin
               mon_e = exp_req_q[0];
               chk("req_addr",  mem_o_addr,          mon_e[136:73]);
               chk("req_wen",   64'(mem_o_wen),      64'(mon_e[72]));
               chk("req_wdata", mem_o_wdata,         mon_e[71:8]);
               chk("req_wstrb", 64'(mem_o_wstrb),    64'(mon_e[7:0]));
               if (mem_i_req_ready) void'(exp_req_q.pop_front());
            end
         end
         if (memory_o_misalign) begin
            if (exp_mis_q.size() == 0) fail_evt("misalign_unexpected");
            else chk("misalign_outputs", 64'({mem_o_req_valid, memory_o_stall_req}),
                     64'(exp_mis_q.pop_front()));
         end
         if (memory_o_stall_req) begin
            stall_run++;
         end else if (stall_run > 0) begin
            if (exp_stall_q.size() == 0 || exp_mem_q.size() == 0) fail_evt("done_unexpected");
            else begin
               chk("stall_cycles", 64'(stall_run), 64'(exp_stall_q.pop_front()));
               chk("memdata_done", memory_o_memdata, exp_mem_q.pop_front());
            end
            stall_run = 0;
         end else begin
            chk("memdata_idle", memory_o_memdata, 64'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_access(input logic ren, input logic wen, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sdata,
                            input logic [63:0] rdata, input int delay,
                            input logic [63:0] e_addr, input logic [63:0] e_wdata,
                            input logic [7:0] e_wstrb, input logic [63:0] e_mem,
                            input logic [7:0] e_stall);
      exp_req_q.push_back({e_addr, wen, e_wdata, e_wstrb});
      exp_mem_q.push_back(e_mem);
      exp_stall_q.push_back(e_stall);
      regM_i_mem_ren    = ren;
      regM_i_mem_wen    = wen;
      regM_i_funct3     = f3;
      regM_i_alu_result = addr;
      regM_i_store_data = sdata;
      mem_i_req_ready   = (delay == 0);
      for (int k = 0; k < delay; k++) begin
         @(posedge clk); #1;
         if (k == delay - 1) mem_i_req_ready = 1'b1;
      end
      @(posedge clk); #1;
      mem_i_req_ready  = 1'b0;
      mem_i_resp_valid = 1'b1;
      mem_i_resp_rdata = rdata;
      @(posedge clk); #1;
      mem_i_resp_valid = 1'b0;
      mem_i_resp_rdata = 64'd0;
      @(posedge clk); #1;
      regM_i_mem_ren = 1'b0;
      regM_i_mem_wen = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_misaligned(input logic ren, input logic wen, input logic [2:0] f3,
                                input logic [63:0] addr);
      exp_mis_q.push_back(2'b00);
      regM_i_mem_ren    = ren;
      regM_i_mem_wen    = wen;
      regM_i_funct3     = f3;
      regM_i_alu_result = addr;
      mem_i_req_ready   = 1'b1;
      @(posedge clk); #1;
      regM_i_mem_ren  = 1'b0;
      regM_i_mem_wen  = 1'b0;
      mem_i_req_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", 64'(mem_o_req_valid),    64'd0);
      chk("rst_addr",      mem_o_addr,              64'd0);
      chk("rst_wen",       64'(mem_o_wen),          64'd0);
      chk("rst_wdata",     mem_o_wdata,             64'd0);
      chk("rst_wstrb",     64'(mem_o_wstrb),        64'd0);
      chk("rst_memdata",   memory_o_memdata,        64'd0);
      chk("rst_stall",     64'(memory_o_stall_req), 64'd0);
      chk("rst_misalign",  64'(memory_o_misalign),  64'd0);
      chk("rst_state",     64'(dbg_state_o),        64'(ST_IDLE));
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // lb / sh / lw with late ready / misaligned ld / lwu
      do_access(1, 0, F3_B,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0,
                64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 8'd2);
      do_access(0, 1, F3_H,  64'h2006, 64'hABCD, 64'h1122_3344_5566_7788, 0,
                64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0, 8'd2);
      do_access(1, 0, F3_W,  64'h5008, 64'h0, 64'h1234_5678_8765_4321, 3,
                64'h5008, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 8'd5);
      do_misaligned(1, 0, F3_D, 64'h3004);
      do_access(1, 0, F3_WU, 64'h4004, 64'h0, 64'hF000_0001_0000_0000, 0,
                64'h4000, 64'h0, 8'h00, 64'h0000_0000_F000_0001, 8'd2);

      // remaining store sizes and load variants
      do_access(0, 1, F3_B,  64'h7005, 64'h5A, 64'h0, 0,
                64'h7000, 64'h0000_5A00_0000_0000, 8'h20, 64'h0, 8'd2);
      do_access(0, 1, F3_W,  64'h8004, 64'hDEAD_BEEF, 64'h0, 1,
                64'h8000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0, 8'd3);
      do_access(0, 1, F3_D,  64'h9000, 64'h0123_4567_89AB_CDEF, 64'h0, 0,
                64'h9000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 8'd2);
      do_access(1, 0, F3_HU, 64'hA002, 64'h0, 64'h0000_0000_ABCD_0000, 0,
                64'hA000, 64'h0, 8'h00, 64'h0000_0000_0000_ABCD, 8'd2);
      do_access(1, 0, F3_H,  64'hA006, 64'h0, 64'h8001_0000_0000_0000, 0,
                64'hA000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 8'd2);
      do_access(1, 0, F3_BU, 64'hB007, 64'h0, 64'hFE00_0000_0000_0000, 0,
                64'hB000, 64'h0, 8'h00, 64'h0000_0000_0000_00FE, 8'd2);
      do_access(1, 0, F3_D,  64'hC000, 64'h0, 64'hCAFE_BABE_1234_5678, 2,
                64'hC000, 64'h0, 8'h00, 64'hCAFE_BABE_1234_5678, 8'd4);
      do_misaligned(0, 1, F3_H, 64'h2001);
      do_misaligned(1, 0, F3_WU, 64'h2002);

      // reset while waiting for the response; the late response must be dropped
      exp_req_q.push_back({64'hD000, 1'b0, 64'h0, 8'h00});
      exp_mem_q.push_back(64'h0);
      exp_stall_q.push_back(8'd2);
      regM_i_mem_ren    = 1'b1;
      regM_i_funct3     = F3_W;
      regM_i_alu_result = 64'hD000;
      mem_i_req_ready   = 1'b1;
      @(posedge clk); #1;
      mem_i_req_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst              = 1'b0;
      regM_i_mem_ren   = 1'b0;
      mem_i_resp_valid = 1'b1;
      mem_i_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("rst_wait_state", 64'(dbg_state_o), 64'(ST_IDLE));
      @(posedge clk); #1;
      mem_i_resp_valid = 1'b0;
      mem_i_resp_rdata = 64'd0;
      chk("late_resp_state", 64'(dbg_state_o), 64'(ST_IDLE));

      // access after the abandoned one still works
      do_access(1, 0, F3_B, 64'hE001, 64'h0, 64'h0000_0000_0000_7F00, 0,
                64'hE000, 64'h0, 8'h00, 64'h0000_0000_0000_007F, 8'd2);

      repeat (3) @(posedge clk);
      #1;
      chk("req_queue_left",   64'(exp_req_q.size()),   64'd0);
      chk("mem_queue_left",   64'(exp_mem_q.size()),   64'd0);
      chk("stall_queue_left", 64'(exp_stall_q.size()), 64'd0);
      chk("mis_queue_left",   64'(exp_mis_q.size()),   64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
